// File: rtl/stack_seq_pkg.sv
// ============================================================================
// stack_seq_pkg : shared state encoding and mux-select codes for stack_seq
// Rev 1.0
// ============================================================================
`default_nettype none

package stack_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DRAIN    = 3'd1,
    ST_PUSH_PC  = 3'd2,
    ST_PUSH_CCR = 3'd3,
    ST_POP_CCR  = 3'd4,
    ST_POP_PC   = 3'd5,
    ST_JUMP     = 3'd6,
    ST_LOAD     = 3'd7
  } state_t;

  localparam logic [1:0] c_pcs_next   = 2'b00;
  localparam logic [1:0] c_pcs_popped = 2'b01;
  localparam logic [1:0] c_pcs_vector = 2'b10;
  localparam logic [1:0] c_pcs_call   = 2'b11;

  localparam logic [1:0] c_mds_normal = 2'b00;
  localparam logic [1:0] c_mds_pc     = 2'b01;
  localparam logic [1:0] c_mds_ccr    = 2'b10;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stack_word_counter.sv
// ============================================================================
// stack_word_counter : loadable up/down counter with exact terminal compare
// Rev 1.0
// ============================================================================
`default_nettype none

module stack_word_counter #(
  parameter int W     = 2,
  parameter int LOW_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [W-1:0]     i_load_val,
  input  logic             i_en,
  input  logic             i_down,
  input  logic [W-1:0]     i_term_val,
  output logic [LOW_W-1:0] o_low,
  output logic             o_term
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= i_down ? (r_count - 1'b1) : (r_count + 1'b1);
    end
  end

  assign o_low  = r_count[LOW_W-1:0];
  assign o_term = (r_count == i_term_val);

endmodule

`default_nettype wire

// File: rtl/stack_seq.sv
// ============================================================================
// stack_seq : one FSM sequencing call/ret/rti/interrupt stack transfers
// Rev 1.0
// ============================================================================
`default_nettype none

module stack_seq
  import stack_seq_pkg::*;
#(
  parameter int PC_WORDS = 2,
  parameter int INT_WAIT = 1,
  parameter int IDX_W    = (PC_WORDS > 1) ? $clog2(PC_WORDS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_call_req,
  input  logic             i_ret_req,
  input  logic             i_rti_req,
  input  logic             i_int_req,
  input  logic             i_hold,
  output logic             o_int_ack,
  output logic             o_mem_wr,
  output logic             o_mem_rd,
  output logic             o_stack,
  output logic [1:0]       o_mem_data_sel,
  output logic [IDX_W-1:0] o_word_idx,
  output logic             o_pop_pc,
  output logic             o_pop_ccr,
  output logic             o_freeze_pc,
  output logic             o_freeze_cu,
  output logic [1:0]       o_pc_sel,
  output logic             o_flush,
  output logic             o_busy
);

  localparam int CNT_W = max_int(IDX_W, $clog2(INT_WAIT + 1));
  localparam logic [CNT_W-1:0] c_pc_last    = CNT_W'(PC_WORDS - 1);
  localparam logic [CNT_W-1:0] c_drain_last = CNT_W'((INT_WAIT > 0) ? (INT_WAIT - 1) : 0);

  state_t r_state;
  logic   r_int_path;
  logic   r_int_ack;

  logic             w_cnt_load;
  logic [CNT_W-1:0] w_cnt_load_val;
  logic             w_cnt_en;
  logic             w_cnt_down;
  logic [CNT_W-1:0] w_cnt_term_val;
  logic [IDX_W-1:0] w_cnt_low;
  logic             w_cnt_term;
  logic             w_op_req;
  logic             w_accept_int;

  assign w_op_req     = i_call_req | i_ret_req | i_rti_req;
  assign w_accept_int = i_int_req & ~w_op_req & ~i_hold;

  stack_word_counter #(
    .W     (CNT_W),
    .LOW_W (IDX_W)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_load_val),
    .i_en       (w_cnt_en),
    .i_down     (w_cnt_down),
    .i_term_val (w_cnt_term_val),
    .o_low      (w_cnt_low),
    .o_term     (w_cnt_term)
  );

  // Pops walk the words top-down so they mirror the push order.
  always_comb begin
    w_cnt_load     = 1'b0;
    w_cnt_load_val = '0;
    w_cnt_en       = 1'b0;
    w_cnt_down     = 1'b0;
    w_cnt_term_val = c_pc_last;
    case (r_state)
      ST_IDLE: begin
        w_cnt_load     = 1'b1;
        w_cnt_load_val = (!i_call_req && (i_ret_req || i_rti_req)) ? c_pc_last : '0;
      end
      ST_PUSH_PC: begin
        w_cnt_term_val = c_pc_last;
        w_cnt_load     = w_cnt_term;
        w_cnt_en       = ~w_cnt_term;
      end
      ST_POP_PC: begin
        w_cnt_term_val = '0;
        w_cnt_load     = w_cnt_term;
        w_cnt_en       = ~w_cnt_term;
        w_cnt_down     = 1'b1;
      end
      ST_DRAIN: begin
        w_cnt_term_val = c_drain_last;
        w_cnt_load     = ~i_hold & w_cnt_term;
        w_cnt_en       = ~i_hold & ~w_cnt_term;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_int_path <= 1'b0;
      r_int_ack  <= 1'b0;
    end else begin
      r_int_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_call_req) begin
            r_state    <= ST_PUSH_PC;
            r_int_path <= 1'b0;
          end else if (i_ret_req) begin
            r_state <= ST_POP_PC;
          end else if (i_rti_req) begin
            r_state <= ST_POP_CCR;
          end else if (w_accept_int) begin
            r_state    <= (INT_WAIT == 0) ? ST_PUSH_PC : ST_DRAIN;
            r_int_path <= 1'b1;
            r_int_ack  <= 1'b1;
          end
        end
        ST_DRAIN:    if (!i_hold && w_cnt_term) r_state <= ST_PUSH_PC;
        ST_PUSH_PC:  if (w_cnt_term) r_state <= r_int_path ? ST_PUSH_CCR : ST_JUMP;
        ST_PUSH_CCR: r_state <= ST_JUMP;
        ST_POP_CCR:  r_state <= ST_POP_PC;
        ST_POP_PC:   if (w_cnt_term) r_state <= ST_LOAD;
        ST_JUMP:     r_state <= ST_IDLE;
        ST_LOAD:     r_state <= ST_IDLE;
        default:     r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_int_ack = r_int_ack;

  always_comb begin
    o_mem_wr       = 1'b0;
    o_mem_rd       = 1'b0;
    o_stack        = 1'b0;
    o_mem_data_sel = c_mds_normal;
    o_word_idx     = '0;
    o_pop_pc       = 1'b0;
    o_pop_ccr      = 1'b0;
    o_freeze_pc    = 1'b0;
    o_freeze_cu    = 1'b0;
    o_pc_sel       = c_pcs_next;
    o_flush        = 1'b0;
    o_busy         = (r_state != ST_IDLE);
    case (r_state)
      ST_DRAIN: o_freeze_pc = 1'b1;
      ST_PUSH_PC: begin
        o_mem_wr       = 1'b1;
        o_stack        = 1'b1;
        o_mem_data_sel = c_mds_pc;
        o_word_idx     = w_cnt_low;
        o_freeze_pc    = 1'b1;
        o_freeze_cu    = 1'b1;
      end
      ST_PUSH_CCR: begin
        o_mem_wr       = 1'b1;
        o_stack        = 1'b1;
        o_mem_data_sel = c_mds_ccr;
        o_freeze_pc    = 1'b1;
        o_freeze_cu    = 1'b1;
      end
      ST_POP_CCR: begin
        o_mem_rd    = 1'b1;
        o_stack     = 1'b1;
        o_pop_ccr   = 1'b1;
        o_freeze_pc = 1'b1;
        o_freeze_cu = 1'b1;
      end
      ST_POP_PC: begin
        o_mem_rd    = 1'b1;
        o_stack     = 1'b1;
        o_pop_pc    = 1'b1;
        o_word_idx  = w_cnt_low;
        o_freeze_pc = 1'b1;
        o_freeze_cu = 1'b1;
      end
      ST_JUMP: begin
        o_pc_sel = r_int_path ? c_pcs_vector : c_pcs_call;
        o_flush  = 1'b1;
      end
      ST_LOAD: begin
        o_pc_sel = c_pcs_popped;
        o_flush  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_stack_seq.sv
// ============================================================================
// tb_stack_seq : scoreboard bench for stack_seq (2/1 and 4/0 configurations)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_stack_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic a_call = 0, a_ret = 0, a_rti = 0, a_int = 0, a_hold = 0;
  logic a_ack, a_wr, a_rd, a_stk, a_ppc, a_pccr, a_fpc, a_fcu, a_fl, a_busy;
  logic [1:0] a_dsel, a_psel;
  logic [0:0] a_widx;

  logic b_call = 0, b_ret = 0, b_rti = 0, b_int = 0, b_hold = 0;
  logic b_ack, b_wr, b_rd, b_stk, b_ppc, b_pccr, b_fpc, b_fcu, b_fl, b_busy;
  logic [1:0] b_dsel, b_psel;
  logic [1:0] b_widx;

  stack_seq #(.PC_WORDS(2), .INT_WAIT(1)) u_dut_a (
    .clk(clk), .rst(rst),
    .i_call_req(a_call), .i_ret_req(a_ret), .i_rti_req(a_rti), .i_int_req(a_int), .i_hold(a_hold),
    .o_int_ack(a_ack), .o_mem_wr(a_wr), .o_mem_rd(a_rd), .o_stack(a_stk), .o_mem_data_sel(a_dsel),
    .o_word_idx(a_widx), .o_pop_pc(a_ppc), .o_pop_ccr(a_pccr), .o_freeze_pc(a_fpc),
    .o_freeze_cu(a_fcu), .o_pc_sel(a_psel), .o_flush(a_fl), .o_busy(a_busy)
  );

  stack_seq #(.PC_WORDS(4), .INT_WAIT(0)) u_dut_b (
    .clk(clk), .rst(rst),
    .i_call_req(b_call), .i_ret_req(b_ret), .i_rti_req(b_rti), .i_int_req(b_int), .i_hold(b_hold),
    .o_int_ack(b_ack), .o_mem_wr(b_wr), .o_mem_rd(b_rd), .o_stack(b_stk), .o_mem_data_sel(b_dsel),
    .o_word_idx(b_widx), .o_pop_pc(b_ppc), .o_pop_ccr(b_pccr), .o_freeze_pc(b_fpc),
    .o_freeze_cu(b_fcu), .o_pc_sel(b_psel), .o_flush(b_fl), .o_busy(b_busy)
  );

  // Output snapshot: {ack,wr,rd,stack,dsel[2],widx[4],pop_pc,pop_ccr,frz_pc,frz_cu,pc_sel[2],flush,busy}
  logic [17:0] w_vec_a, w_vec_b;
  assign w_vec_a = {a_ack, a_wr, a_rd, a_stk, a_dsel, 4'(a_widx), a_ppc, a_pccr,
                    a_fpc, a_fcu, a_psel, a_fl, a_busy};
  assign w_vec_b = {b_ack, b_wr, b_rd, b_stk, b_dsel, 4'(b_widx), b_ppc, b_pccr,
                    b_fpc, b_fcu, b_psel, b_fl, b_busy};

  localparam logic [17:0] c_ack  = 18'h20000;
  localparam logic [17:0] c_idle = 18'h00000;

  int          n_cmp = 0;
  int          n_err = 0;
  string       cur_tag;
  logic [17:0] exp_q[$];

  function automatic logic [17:0] ev(input logic wr, rd, stk, input logic [1:0] dsel,
                                     input logic [3:0] widx, input logic ppc, pccr, fpc, fcu,
                                     input logic [1:0] psel, input logic fl);
    return {1'b0, wr, rd, stk, dsel, widx, ppc, pccr, fpc, fcu, psel, fl, 1'b1};
  endfunction

  function automatic logic [17:0] e_push(input logic [3:0] i);
    return ev(1, 0, 1, 2'b01, i, 0, 0, 1, 1, 2'b00, 0);
  endfunction
  function automatic logic [17:0] e_pop(input logic [3:0] i);
    return ev(0, 1, 1, 2'b00, i, 1, 0, 1, 1, 2'b00, 0);
  endfunction
  function automatic logic [17:0] e_push_ccr();
    return ev(1, 0, 1, 2'b10, 4'd0, 0, 0, 1, 1, 2'b00, 0);
  endfunction
  function automatic logic [17:0] e_pop_ccr();
    return ev(0, 1, 1, 2'b00, 4'd0, 0, 1, 1, 1, 2'b00, 0);
  endfunction
  function automatic logic [17:0] e_drain();
    return ev(0, 0, 0, 2'b00, 4'd0, 0, 0, 1, 0, 2'b00, 0);
  endfunction
  function automatic logic [17:0] e_jump(input logic [1:0] psel);
    return ev(0, 0, 0, 2'b00, 4'd0, 0, 0, 0, 0, psel, 1);
  endfunction

  task automatic check_eq(input string tag, input logic [17:0] got, input logic [17:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %05h expected %05h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one cycle per queued expectation; op requests last one edge, int_req until ack.
  task automatic run_q(input bit sel_b);
    logic [17:0] got;
    while (exp_q.size() > 0) begin
      @(posedge clk);
      #1;
      a_call = 0; a_ret = 0; a_rti = 0;
      b_call = 0; b_ret = 0; b_rti = 0;
      got = sel_b ? w_vec_b : w_vec_a;
      check_eq(cur_tag, got, exp_q.pop_front());
      if (got[17]) begin
        if (sel_b) b_int = 0; else a_int = 0;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_a", w_vec_a, c_idle);
    check_eq("reset_b", w_vec_b, c_idle);
    rst = 0;
    @(posedge clk);
    #1;

    cur_tag = "call";
    a_call = 1;
    exp_q.push_back(e_push(0));
    run_q(0);
    a_ret = 1;  // arrives while busy, must be dropped
    exp_q.push_back(e_push(1));
    exp_q.push_back(e_jump(2'b11));
    exp_q.push_back(c_idle);
    exp_q.push_back(c_idle);
    run_q(0);

    cur_tag = "ret";
    a_ret = 1;
    exp_q.push_back(e_pop(1));
    exp_q.push_back(e_pop(0));
    exp_q.push_back(e_jump(2'b01));
    exp_q.push_back(c_idle);
    run_q(0);

    cur_tag = "rti";
    a_rti = 1;
    exp_q.push_back(e_pop_ccr());
    exp_q.push_back(e_pop(1));
    exp_q.push_back(e_pop(0));
    exp_q.push_back(e_jump(2'b01));
    exp_q.push_back(c_idle);
    run_q(0);

    cur_tag = "int_hold_gate";
    a_int = 1; a_hold = 1;
    repeat (3) exp_q.push_back(c_idle);
    run_q(0);
    a_hold = 0;
    cur_tag = "int_after_hold";
    exp_q.push_back(e_drain() | c_ack);
    exp_q.push_back(e_push(0));
    exp_q.push_back(e_push(1));
    exp_q.push_back(e_push_ccr());
    exp_q.push_back(e_jump(2'b10));
    exp_q.push_back(c_idle);
    run_q(0);

    cur_tag = "int_drain_hold";
    a_int = 1;
    exp_q.push_back(e_drain() | c_ack);
    run_q(0);
    a_hold = 1;
    exp_q.push_back(e_drain());
    exp_q.push_back(e_drain());
    run_q(0);
    a_hold = 0;
    exp_q.push_back(e_push(0));
    exp_q.push_back(e_push(1));
    exp_q.push_back(e_push_ccr());
    exp_q.push_back(e_jump(2'b10));
    exp_q.push_back(c_idle);
    run_q(0);

    cur_tag = "ret_beats_int";
    a_int = 1; a_ret = 1;
    exp_q.push_back(e_pop(1));
    exp_q.push_back(e_pop(0));
    exp_q.push_back(e_jump(2'b01));
    exp_q.push_back(c_idle);
    exp_q.push_back(e_drain() | c_ack);
    exp_q.push_back(e_push(0));
    exp_q.push_back(e_push(1));
    exp_q.push_back(e_push_ccr());
    exp_q.push_back(e_jump(2'b10));
    exp_q.push_back(c_idle);
    run_q(0);

    cur_tag = "rst_mid_push";
    a_call = 1;
    exp_q.push_back(e_push(0));
    run_q(0);
    #2;
    rst = 1;
    #1;
    check_eq("rst_async", w_vec_a, c_idle);
    @(posedge clk);
    #1;
    check_eq("rst_held", w_vec_a, c_idle);
    rst = 0;
    cur_tag = "after_rst";
    repeat (3) exp_q.push_back(c_idle);
    run_q(0);

    cur_tag = "b_int_w4";
    b_int = 1;
    exp_q.push_back(e_push(0) | c_ack);
    exp_q.push_back(e_push(1));
    exp_q.push_back(e_push(2));
    exp_q.push_back(e_push(3));
    exp_q.push_back(e_push_ccr());
    exp_q.push_back(e_jump(2'b10));
    exp_q.push_back(c_idle);
    run_q(1);

    cur_tag = "b_ret_w4";
    b_ret = 1;
    exp_q.push_back(e_pop(3));
    exp_q.push_back(e_pop(2));
    exp_q.push_back(e_pop(1));
    exp_q.push_back(e_pop(0));
    exp_q.push_back(e_jump(2'b01));
    exp_q.push_back(c_idle);
    run_q(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
